hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Pipeline hazard controller sitting beside the decode stage.
- Tracks in-flight destination registers in EX, MEM and WB.
- Generates the decode stall, the decode-stage Rs forward select (XD_fwd) and the EX operand-forward selects.
- Shares result buses between consumers so branch/JR resolution in decode and ALU operands in EX get correct values; the register file's write-before-read bypass covers WB.

Parameters:
- CNT_W, 16: width of saturating stall-cycle performance counter.
- MAX_STALL, 4: consecutive stall cycles after which watchdog error sets.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  decode holds a real instruction.
- id_rs  input  3  Instruction[10:8].
- id_rs_used  input  1  instruction reads Rs in EX.
- id_rt  input  3  Instruction[7:5].
- id_rt_used  input  1  instruction reads Rt in EX.
- id_rs_early  input  1  Rs consumed in decode (branch, JR, JALR).
- id_regwrite  input  1  decoded RegWrite.
- id_wreg  input  3  decoded Write_register.
- id_memread  input  1  decoded MemRead (load).
- flush  input  1  kill decode instruction (taken branch/jump, siic, rti).
- stall  output  1  hold PC and IF/ID; inject bubble into EX.
- xd_fwd  output  1  decode Rs comes from MEM-stage ALU result.
- ex_fwd_a  output  2  EX operand A select: 00 RF, 01 MEM result, 10 WB data.
- ex_fwd_b  output  2  EX operand B select, same encoding.
- ex_valid, mem_valid, wb_valid  output  1 each  scoreboard entry valid (debug).
- stall_cnt  output  CNT_W  total stall cycles, saturating.
- err  output  1  sticky watchdog error.

Behaviour:
- State: three entries EX, MEM, WB, each {v, wreg[2:0], ld}. An entry has v=1 only if its instruction writes a register.
- Registered state: ex_fwd_a/b, consecutive-stall counter, stall_cnt, err.
- Reset (rst_n low, async): all entry v=0, ex_fwd_a/b=00, stall_cnt=0, consecutive counter=0, err=0. Combinational outputs then evaluate to stall=0, xd_fwd=0.
- match(X,r) = X.v & X.wreg==r. src_ex(r) is id_rs_used or id_rt_used for the matching source.
- Stall, combinational, FWD_EN undefined: stall = id_valid & !flush & (any src_ex or id_rs_early source matches EX or MEM).
- Stall, with FWD_EN: stall = id_valid & !flush & ((src_ex match EX & EX.ld) | (id_rs_early & (match EX | (match MEM & MEM.ld)))).
- xd_fwd = FWD_EN & id_valid & id_rs_early & match(MEM,id_rs) & !MEM.ld & !stall; otherwise 0.
- Each rising edge:
  - WB<=MEM and MEM<=EX.
  - EX<={id_valid & id_regwrite & !stall & !flush, id_wreg, id_memread}.
  - ex_fwd_a/b latched alongside EX: 01 if source matched EX, else 10 if matched MEM, else 00 (youngest wins).
  - ex_fwd_a/b latch 00 when bubble, unused source, or FWD_EN undefined.
- flush has priority over stall: stall forced 0 and EX receives a bubble.
- Simultaneous Rs and Rt hazards produce one stall; resolution repeats each cycle until clear.
- Maximum stall: 2 cycles without FWD_EN, 1 cycle for load-use, 2 cycles for a branch on a load result.
- Consecutive counter increments while stall=1 and clears on any non-stall cycle.
  - When it reaches MAX_STALL, err sets and stays set until reset.
  - The counter saturates at MAX_STALL.
- stall_cnt increments on each stall cycle and holds at all ones.
- Reset asserted mid-stall clears everything immediately; the first cycle after release has stall=0.

Optional Feature:
- FWD_EN defined: EX->EX and MEM->EX forwarding, plus MEM->decode Rs forwarding (xd_fwd); stalls only on load-use and on early-Rs hazards as above.
- FWD_EN undefined: pure interlock; ex_fwd_a/b and xd_fwd tied to 0; every RAW hazard against EX or MEM stalls.

Test Plan:
- Back-to-back ADD R1 then ADD R2,R1,R3, no FWD_EN -> stall=1 for 2 cycles, then EX issues with ex_fwd_a=00; stall_cnt=2.
- Same pair with FWD_EN -> stall=0; second instruction enters EX with ex_fwd_a=01. With one independent instruction between them -> ex_fwd_a=10.
- LD R4 then ADD R5,R4,R4, FWD_EN -> exactly 1 stall cycle; bubble in EX; then ex_fwd_a=ex_fwd_b=10.
- ADDI R6 then NOP then BEQZ R6, FWD_EN -> no stall, xd_fwd=1 in BEQZ decode cycle. ADDI directly before BEQZ -> 1 stall, then xd_fwd=1.
- Hazard pending with flush=1 in the same cycle -> stall=0 and EX entry v=0. rst_n pulsed low mid-stall -> all outputs 0 asynchronously.
- Force id_* to hold a hazard with a frozen EX (test hook, MAX_STALL=4) -> err=1 on the 4th consecutive stall cycle, stays 1 after hazard clears, cleared only by rst_n.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Decode-side handshake between the decode stage and the hazard scoreboard.
// master = decode stage (drives instruction fields), slave = scoreboard.
interface hazard_scoreboard_if;
  logic       id_valid;
  logic [2:0] id_rs;
  logic       id_rs_used;
  logic [2:0] id_rt;
  logic       id_rt_used;
  logic       id_rs_early;
  logic       id_regwrite;
  logic [2:0] id_wreg;
  logic       id_memread;
  logic       flush;
  logic       stall;
  logic       xd_fwd;
  logic [1:0] ex_fwd_a;
  logic [1:0] ex_fwd_b;

  modport master (
    output id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_rs_early,
           id_regwrite, id_wreg, id_memread, flush,
    input  stall, xd_fwd, ex_fwd_a, ex_fwd_b
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_rs_early,
           id_regwrite, id_wreg, id_memread, flush,
    output stall, xd_fwd, ex_fwd_a, ex_fwd_b
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard scoreboard: stall generation, operand forward selects, stall watchdog.
// Define FWD_EN for EX/MEM forwarding and MEM->decode Rs forwarding; default is pure interlock.
module hazard_scoreboard #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_STALL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_scoreboard_if.slave hz,
  output logic             ex_valid,
  output logic             mem_valid,
  output logic             wb_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             err
);

  localparam int unsigned ConsW = $clog2(MAX_STALL + 1);
  localparam logic [ConsW-1:0] ConsMax = ConsW'(MAX_STALL);

  // Scoreboard entries; WB only needs validity since the RF bypass covers it.
  logic       ex_v_q, mem_v_q, wb_v_q;
  logic [2:0] ex_wreg_q, mem_wreg_q;

  logic             rs_ex, rs_mem, rt_ex, rt_mem;
  logic             hazard, stall_now, issue;
  logic [ConsW-1:0] cons_q, cons_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             err_q, err_d;

  always_comb begin
    rs_ex  = ex_v_q  && (ex_wreg_q  == hz.id_rs);
    rs_mem = mem_v_q && (mem_wreg_q == hz.id_rs);
    rt_ex  = ex_v_q  && (ex_wreg_q  == hz.id_rt);
    rt_mem = mem_v_q && (mem_wreg_q == hz.id_rt);
  end

`ifdef FWD_EN
  logic       ex_ld_q, mem_ld_q;
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

  // Only load results in EX and early-Rs reads of unfinished values need to wait.
  always_comb begin
    hazard = (((hz.id_rs_used && rs_ex) || (hz.id_rt_used && rt_ex)) && ex_ld_q) ||
             (hz.id_rs_early && (rs_ex || (rs_mem && mem_ld_q)));
  end

  always_comb begin
    fwd_a_d = 2'b00;
    fwd_b_d = 2'b00;
    if (issue && hz.id_rs_used) begin
      if (rs_ex)       fwd_a_d = 2'b01;
      else if (rs_mem) fwd_a_d = 2'b10;
    end
    if (issue && hz.id_rt_used) begin
      if (rt_ex)       fwd_b_d = 2'b01;
      else if (rt_mem) fwd_b_d = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ld_q  <= 1'b0;
      mem_ld_q <= 1'b0;
      fwd_a_q  <= 2'b00;
      fwd_b_q  <= 2'b00;
    end else begin
      ex_ld_q  <= hz.id_memread;
      mem_ld_q <= ex_ld_q;
      fwd_a_q  <= fwd_a_d;
      fwd_b_q  <= fwd_b_d;
    end
  end

  assign hz.xd_fwd   = hz.id_valid && hz.id_rs_early && rs_mem && !mem_ld_q && !stall_now;
  assign hz.ex_fwd_a = fwd_a_q;
  assign hz.ex_fwd_b = fwd_b_q;
`else
  logic unused_memread;
  assign unused_memread = hz.id_memread;

  always_comb begin
    hazard = ((hz.id_rs_used || hz.id_rs_early) && (rs_ex || rs_mem)) ||
             (hz.id_rt_used && (rt_ex || rt_mem));
  end

  assign hz.xd_fwd   = 1'b0;
  assign hz.ex_fwd_a = 2'b00;
  assign hz.ex_fwd_b = 2'b00;
`endif

  // flush wins over stall so a killed instruction never holds the front end.
  always_comb begin
    stall_now = hz.id_valid && !hz.flush && hazard;
    issue     = hz.id_valid && !hz.flush && !stall_now;
  end

  always_comb begin
    cons_d      = '0;
    stall_cnt_d = stall_cnt_q;
    err_d       = err_q;
    if (stall_now) begin
      cons_d = (cons_q == ConsMax) ? cons_q : cons_q + 1'b1;
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (cons_d == ConsMax) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v_q      <= 1'b0;
      ex_wreg_q   <= 3'd0;
      mem_v_q     <= 1'b0;
      mem_wreg_q  <= 3'd0;
      wb_v_q      <= 1'b0;
      cons_q      <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      wb_v_q      <= mem_v_q;
      mem_v_q     <= ex_v_q;
      mem_wreg_q  <= ex_wreg_q;
      ex_v_q      <= issue && hz.id_regwrite;
      ex_wreg_q   <= hz.id_wreg;
      cons_q      <= cons_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  assign hz.stall  = stall_now;
  assign ex_valid  = ex_v_q;
  assign mem_valid = mem_v_q;
  assign wb_valid  = wb_v_q;
  assign stall_cnt = stall_cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; expectations follow FWD_EN when it is defined.
module tb_hazard_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        ex_valid, mem_valid, wb_valid, err;
  logic [15:0] stall_cnt;
  int          n_checks;
  int          n_fail;

  hazard_scoreboard_if hz ();

  hazard_scoreboard #(
    .CNT_W    (16),
    .MAX_STALL(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .hz       (hz),
    .ex_valid (ex_valid),
    .mem_valid(mem_valid),
    .wb_valid (wb_valid),
    .stall_cnt(stall_cnt),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] rs, input logic rs_used,
                       input logic [2:0] rt, input logic rt_used, input logic early,
                       input logic rw, input logic [2:0] wreg, input logic mr,
                       input logic fl);
    hz.id_valid    = v;
    hz.id_rs       = rs;
    hz.id_rs_used  = rs_used;
    hz.id_rt       = rt;
    hz.id_rt_used  = rt_used;
    hz.id_rs_early = early;
    hz.id_regwrite = rw;
    hz.id_wreg     = wreg;
    hz.id_memread  = mr;
    hz.flush       = fl;
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    #11;
    rst_n = 1'b1;
    #1;
    check("reset_stall", 32'(hz.stall), 0);
    check("reset_xd_fwd", 32'(hz.xd_fwd), 0);
    check("reset_fwd_a", 32'(hz.ex_fwd_a), 0);
    check("reset_fwd_b", 32'(hz.ex_fwd_b), 0);
    check("reset_valid", 32'({ex_valid, mem_valid, wb_valid}), 0);
    check("reset_cnt", 32'(stall_cnt), 0);
    check("reset_err", 32'(err), 0);

    // ADD R1 ; ADD R2,R1,R3
    drive(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
    check("add1_stall", 32'(hz.stall), 0);
    tick();
    check("add1_ex_valid", 32'(ex_valid), 1);
    drive(1'b1, 3'd1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
`ifdef FWD_EN
    check("b2b_stall", 32'(hz.stall), 0);
    tick();
    check("b2b_fwd_a", 32'(hz.ex_fwd_a), 1);
    check("b2b_fwd_b", 32'(hz.ex_fwd_b), 0);
`else
    check("b2b_stall_c1", 32'(hz.stall), 1);
    tick();
    check("b2b_bubble", 32'(ex_valid), 0);
    check("b2b_stall_c2", 32'(hz.stall), 1);
    tick();
    check("b2b_stall_c3", 32'(hz.stall), 0);
    tick();
    check("b2b_fwd_a", 32'(hz.ex_fwd_a), 0);
    check("b2b_issue", 32'(ex_valid), 1);
    check("b2b_cnt", 32'(stall_cnt), 2);
`endif
    idle(3);

    // ADD R1 ; ADD R7 ; ADD R2,R1,R3
    drive(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'd5, 1'b1, 3'd6, 1'b1, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0);
    check("gap_mid_stall", 32'(hz.stall), 0);
    tick();
    drive(1'b1, 3'd1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
`ifdef FWD_EN
    check("gap_stall", 32'(hz.stall), 0);
    tick();
    check("gap_fwd_a", 32'(hz.ex_fwd_a), 2);
`else
    check("gap_stall", 32'(hz.stall), 1);
    tick();
    check("gap_stall_clear", 32'(hz.stall), 0);
    tick();
    check("gap_fwd_a", 32'(hz.ex_fwd_a), 0);
    check("gap_cnt", 32'(stall_cnt), 3);
`endif
    idle(3);

    // LD R4 ; ADD R5,R4,R4
    drive(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0);
    tick();
    drive(1'b1, 3'd4, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0);
    check("ldu_stall", 32'(hz.stall), 1);
    tick();
    check("ldu_bubble", 32'(ex_valid), 0);
`ifdef FWD_EN
    check("ldu_stall_clear", 32'(hz.stall), 0);
    tick();
    check("ldu_fwd_a", 32'(hz.ex_fwd_a), 2);
    check("ldu_fwd_b", 32'(hz.ex_fwd_b), 2);
    check("ldu_cnt", 32'(stall_cnt), 1);
`else
    check("ldu_stall_c2", 32'(hz.stall), 1);
    tick();
    check("ldu_stall_clear", 32'(hz.stall), 0);
    tick();
    check("ldu_fwd_ab", 32'({hz.ex_fwd_a, hz.ex_fwd_b}), 0);
    check("ldu_cnt", 32'(stall_cnt), 5);
`endif
    idle(3);

    // ADDI R6 ; NOP ; BEQZ R6
    drive(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    check("nop_no_entry", 32'(ex_valid), 0);
    drive(1'b1, 3'd6, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
`ifdef FWD_EN
    check("br_gap_stall", 32'(hz.stall), 0);
    check("br_gap_xd_fwd", 32'(hz.xd_fwd), 1);
`else
    check("br_gap_stall", 32'(hz.stall), 1);
    check("br_gap_xd_fwd", 32'(hz.xd_fwd), 0);
    tick();
    check("br_gap_clear", 32'(hz.stall), 0);
`endif
    idle(3);

    // ADDI R6 ; BEQZ R6
    drive(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'd6, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    check("br_b2b_stall", 32'(hz.stall), 1);
    check("br_b2b_xd_fwd0", 32'(hz.xd_fwd), 0);
    tick();
`ifdef FWD_EN
    check("br_b2b_clear", 32'(hz.stall), 0);
    check("br_b2b_xd_fwd1", 32'(hz.xd_fwd), 1);
    tick();
    check("br_cnt", 32'(stall_cnt), 2);
`else
    check("br_b2b_stall_c2", 32'(hz.stall), 1);
    tick();
    check("br_b2b_clear", 32'(hz.stall), 0);
    tick();
    check("br_cnt", 32'(stall_cnt), 8);
`endif
    idle(3);

    // Flush beats a pending hazard
    drive(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 3'd1, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1);
    check("flush_stall", 32'(hz.stall), 0);
    tick();
    check("flush_bubble", 32'(ex_valid), 0);
    check("flush_fwd", 32'({hz.ex_fwd_a, hz.ex_fwd_b}), 0);
    idle(3);

    // Reset asserted mid-stall (LD R1 ; ADD R2,R1)
    drive(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
    check("rst_pre_stall", 32'(hz.stall), 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_stall", 32'(hz.stall), 0);
    check("rst_async_valid", 32'({ex_valid, mem_valid, wb_valid}), 0);
    check("rst_async_cnt", 32'(stall_cnt), 0);
    check("rst_async_fwd", 32'({hz.ex_fwd_a, hz.ex_fwd_b, hz.xd_fwd}), 0);
    #2;
    rst_n = 1'b1;
    #1;
    check("rst_release_stall", 32'(hz.stall), 0);
    tick();
    check("rst_first_cycle", 32'(hz.stall), 0);
    check("rst_issue", 32'(ex_valid), 1);
    idle(3);

    // Watchdog: hold an early-Rs hazard against a frozen EX entry
    force dut.ex_v_q = 1'b1;
    force dut.ex_wreg_q = 3'd1;
    drive(1'b1, 3'd1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    check("wd_stall", 32'(hz.stall), 1);
    tick();
    tick();
    tick();
    check("wd_err_after3", 32'(err), 0);
    tick();
    check("wd_err_after4", 32'(err), 1);
    check("wd_cnt", 32'(stall_cnt), 4);
    release dut.ex_v_q;
    release dut.ex_wreg_q;
    idle(3);
    check("wd_clear_stall", 32'(hz.stall), 0);
    check("wd_sticky", 32'(err), 1);
    rst_n = 1'b0;
    #1;
    check("wd_rst_clear", 32'(err), 0);
    #2;
    rst_n = 1'b1;
    tick();
    check("wd_post_rst", 32'(err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
